// File: rtl/pipeline_stall_ctrl_pkg.sv
// pipeline_stall_ctrl_pkg
//   Shared types for the stall/halt controller: FSM state encoding and the
//   bundle of pipeline-register controls driven toward IF/ID and ID/EX.
package pipeline_stall_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_DRAIN  = 2'd1,
    ST_HALTED = 2'd2
  } state_e;

  typedef struct packed {
    logic pc_wen;
    logic if_id_wen;
    logic if_id_flush;
    logic id_ex_bubble;
  } ctrl_t;

  // Hold PC and IF/ID, push a NOP into ID/EX.
  localparam ctrl_t CTRL_FREEZE = '{pc_wen: 1'b0, if_id_wen: 1'b0, if_id_flush: 1'b0, id_ex_bubble: 1'b1};
  // Normal advance.
  localparam ctrl_t CTRL_ADV    = '{pc_wen: 1'b1, if_id_wen: 1'b1, if_id_flush: 1'b0, id_ex_bubble: 1'b0};
  // Taken branch: write the target PC and squash the wrong-path fetch.
  localparam ctrl_t CTRL_FLUSH  = '{pc_wen: 1'b1, if_id_wen: 1'b1, if_id_flush: 1'b1, id_ex_bubble: 1'b0};

endpackage

// File: rtl/pipeline_stall_ctrl_drain_counter.sv
// pipeline_stall_ctrl_drain_counter
//   Loadable down-counter used to time the HLT drain.
//   i_clk, i_rst     : clock, async active-high reset (clears to 0)
//   i_load/i_load_val: load a start value (load wins over decrement)
//   i_dec            : decrement by one, holding at zero
//   o_val            : current count
//   o_zero_next      : count is 1, so the next decrement reaches zero
module pipeline_stall_ctrl_drain_counter #(
  parameter int W = 2
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic         i_load,
  input  logic [W-1:0] i_load_val,
  input  logic         i_dec,
  output logic [W-1:0] o_val,
  output logic         o_zero_next
);

  logic [W-1:0] r_val;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_val <= '0;
    end else if (i_load) begin
      r_val <= i_load_val;
    end else if (i_dec && (r_val != '0)) begin
      r_val <= r_val - W'(1);
    end
  end

  assign o_val       = r_val;
  assign o_zero_next = (r_val == W'(1));

endmodule

// File: rtl/pipeline_stall_ctrl.sv
// pipeline_stall_ctrl
//   Turns hazard-unit stall/halt requests into PC / IF/ID / ID/EX controls,
//   sequences HLT (freeze fetch, drain, sticky halt) and counts stall cycles.
//   i_clk, i_rst       : clock, async active-high reset
//   i_stall_req        : load-use stall request
//   i_hlt_req          : HLT opcode present in IF/ID
//   i_branch_taken     : branch/jump resolved taken in ID
//   i_stat_clr         : synchronous clear of o_stall_count
//   o_pc_wen, o_if_id_wen, o_if_id_flush, o_id_ex_bubble : pipeline controls
//   o_halted           : registered sticky halt flag
//   o_stall_count      : saturating count of accepted stall cycles
//
// state     | meaning
// ----------+-------------------------------------------------------------
// ST_RUN    | normal issue; stall > branch > hlt priority
// ST_DRAIN  | fetch frozen, older instructions completing, timer running
// ST_HALTED | core halted; absorbing until reset
module pipeline_stall_ctrl
  import pipeline_stall_ctrl_pkg::*;
#(
  parameter int DRAIN_CYCLES = 3,
  parameter int CNT_W        = 16
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_stall_req,
  input  logic             i_hlt_req,
  input  logic             i_branch_taken,
  input  logic             i_stat_clr,
  output logic             o_pc_wen,
  output logic             o_if_id_wen,
  output logic             o_if_id_flush,
  output logic             o_id_ex_bubble,
  output logic             o_halted,
  output logic [CNT_W-1:0] o_stall_count
);

  localparam int DW = $clog2(DRAIN_CYCLES + 1);

  state_e           r_state;
  logic             r_halted;
  logic [CNT_W-1:0] r_stall_count;

  ctrl_t            w_ctrl;
  logic             w_go_drain;
  logic             w_stall_acc;
  logic             w_drain_zero_next;
  logic [DW-1:0]    w_drain_val;

  pipeline_stall_ctrl_drain_counter #(.W(DW)) u_drain (
    .i_clk      (i_clk),
    .i_rst      (i_rst),
    .i_load     (w_go_drain),
    .i_load_val (DW'(DRAIN_CYCLES)),
    .i_dec      (r_state == ST_DRAIN),
    .o_val      (w_drain_val),
    .o_zero_next(w_drain_zero_next)
  );

  // Only the terminal-count compare is consumed here; the raw value is kept
  // on the sub-module for debug visibility.
  logic w_unused_drain_val;
  assign w_unused_drain_val = ^w_drain_val;

  always_comb begin
    w_ctrl     = CTRL_FREEZE;
    w_go_drain = 1'b0;
    if (!i_rst) begin
      if (r_state == ST_RUN) begin
        if (i_stall_req) begin
          w_ctrl = CTRL_FREEZE;
        end else if (i_branch_taken) begin
          // A HLT alongside a taken branch is wrong-path and is dropped.
          w_ctrl = CTRL_FLUSH;
        end else if (i_hlt_req) begin
          w_ctrl     = CTRL_FREEZE;
          w_go_drain = 1'b1;
        end else begin
          w_ctrl = CTRL_ADV;
        end
      end
    end
  end

  assign w_stall_acc = (r_state == ST_RUN) && i_stall_req;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state       <= ST_RUN;
      r_halted      <= 1'b0;
      r_stall_count <= '0;
    end else begin
      case (r_state)
        ST_RUN:    if (w_go_drain) r_state <= ST_DRAIN;
        ST_DRAIN:  if (w_drain_zero_next) begin
                     r_state  <= ST_HALTED;
                     r_halted <= 1'b1;
                   end
        ST_HALTED: r_state <= ST_HALTED;
        default:   r_state <= ST_RUN;
      endcase

      if (i_stat_clr) begin
        r_stall_count <= '0;
      end else if (w_stall_acc && (r_stall_count != '1)) begin
        r_stall_count <= r_stall_count + CNT_W'(1);
      end
    end
  end

  assign o_pc_wen       = w_ctrl.pc_wen;
  assign o_if_id_wen    = w_ctrl.if_id_wen;
  assign o_if_id_flush  = w_ctrl.if_id_flush;
  assign o_id_ex_bubble = w_ctrl.id_ex_bubble;
  assign o_halted       = r_halted;
  assign o_stall_count  = r_stall_count;

endmodule

// File: tb/tb_pipeline_stall_ctrl.sv
module tb_pipeline_stall_ctrl;

  typedef struct {
    string      nm;
    logic       rst, stall, hlt, br, clr;
    logic       pc, ifw, fl, bub, halt;
    logic [3:0] cnt;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst, stall_req, hlt_req, branch_taken, stat_clr;
  logic       pc_wen, if_id_wen, if_id_flush, id_ex_bubble, halted;
  logic [3:0] stall_count;

  int tests = 0;
  int fails = 0;

  vec_t tab[$];
  vec_t sb[$];

  pipeline_stall_ctrl #(.DRAIN_CYCLES(3), .CNT_W(4)) dut (
    .i_clk          (clk),
    .i_rst          (rst),
    .i_stall_req    (stall_req),
    .i_hlt_req      (hlt_req),
    .i_branch_taken (branch_taken),
    .i_stat_clr     (stat_clr),
    .o_pc_wen       (pc_wen),
    .o_if_id_wen    (if_id_wen),
    .o_if_id_flush  (if_id_flush),
    .o_id_ex_bubble (id_ex_bubble),
    .o_halted       (halted),
    .o_stall_count  (stall_count)
  );

  always #5 clk = ~clk;

  function automatic vec_t mk(string nm, logic r, logic s, logic h, logic b, logic c,
                              logic pc, logic ifw, logic fl, logic bub, logic halt, int cnt);
    vec_t v;
    v.nm = nm; v.rst = r; v.stall = s; v.hlt = h; v.br = b; v.clr = c;
    v.pc = pc; v.ifw = ifw; v.fl = fl; v.bub = bub; v.halt = halt; v.cnt = 4'(cnt);
    return v;
  endfunction

  // Inputs change just after the active edge; outputs are checked at the
  // falling edge, so cnt/halt expectations are the values after the previous edge.
  task automatic apply(input vec_t v);
    vec_t e;
    logic [8:0] act, req;
    @(posedge clk);
    #1;
    rst = v.rst; stall_req = v.stall; hlt_req = v.hlt; branch_taken = v.br; stat_clr = v.clr;
    sb.push_back(v);
    @(negedge clk);
    e   = sb.pop_front();
    act = {pc_wen, if_id_wen, if_id_flush, id_ex_bubble, halted, stall_count};
    req = {e.pc, e.ifw, e.fl, e.bub, e.halt, e.cnt};
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got pc/ifw/fl/bub/halt/cnt=%b required %b", e.nm, act, req);
    end
    tests++;
    if (!rst && $isunknown(act)) begin
      fails++;
      $display("FAIL %s_x: outputs %b contain X", e.nm, act);
    end
    tests++;
    if (!if_id_wen && if_id_flush) begin
      fails++;
      $display("FAIL %s_wen_flush: if_id_wen=%b if_id_flush=%b required flush=0", e.nm, if_id_wen, if_id_flush);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1; stall_req = 1'b0; hlt_req = 1'b0; branch_taken = 1'b0; stat_clr = 1'b0;

    //             name          rst s h b c   pc w f bub hlt cnt
    tab.push_back(mk("rst0",       1, 0,0,0,0,   0,0,0,1, 0, 0));
    tab.push_back(mk("rst1_br",    1, 0,0,1,0,   0,0,0,1, 0, 0));
    tab.push_back(mk("rst2_st",    1, 1,0,0,0,   0,0,0,1, 0, 0));
    tab.push_back(mk("run_idle",   0, 0,0,0,0,   1,1,0,0, 0, 0));
    tab.push_back(mk("loaduse",    0, 1,0,0,0,   0,0,0,1, 0, 0));
    tab.push_back(mk("after_lu",   0, 0,0,0,0,   1,1,0,0, 0, 1));
    tab.push_back(mk("st_br",      0, 1,0,1,0,   0,0,0,1, 0, 1));
    tab.push_back(mk("br_alone",   0, 0,0,1,0,   1,1,1,0, 0, 2));
    tab.push_back(mk("st_hlt",     0, 1,1,0,0,   0,0,0,1, 0, 2));
    tab.push_back(mk("after_sh",   0, 0,0,0,0,   1,1,0,0, 0, 3));
    tab.push_back(mk("clr",        0, 0,0,0,1,   1,1,0,0, 0, 3));
    tab.push_back(mk("after_clr",  0, 0,0,0,0,   1,1,0,0, 0, 0));
    tab.push_back(mk("hlt_br",     0, 0,1,1,0,   1,1,1,0, 0, 0));
    foreach (tab[i]) apply(tab[i]);

    // Squashed HLT: stays in RUN, not halted, for 10 cycles.
    for (int i = 0; i < 10; i++)
      apply(mk("hlt_br_run", 0, 0,0,0,0, 1,1,0,0, 0, 0));

    // HLT sequence: freeze at once, three DRAIN cycles, halted after 4th edge.
    apply(mk("hlt",        0, 0,1,0,0, 0,0,0,1, 0, 0));
    apply(mk("drain1",     0, 0,0,0,0, 0,0,0,1, 0, 0));
    apply(mk("drain2_in",  0, 1,0,1,0, 0,0,0,1, 0, 0));
    apply(mk("drain3",     0, 0,0,0,0, 0,0,0,1, 0, 0));
    apply(mk("halted",     0, 0,0,0,0, 0,0,0,1, 1, 0));
    apply(mk("halt_st",    0, 1,0,0,0, 0,0,0,1, 1, 0));
    apply(mk("halt_br",    0, 0,0,1,0, 0,0,0,1, 1, 0));
    apply(mk("halt_all",   0, 1,1,1,0, 0,0,0,1, 1, 0));
    apply(mk("halt_hold",  0, 0,0,0,0, 0,0,0,1, 1, 0));
    apply(mk("rst_halted", 1, 0,0,0,0, 0,0,0,1, 0, 0));
    apply(mk("post_rst",   0, 0,0,0,0, 1,1,0,0, 0, 0));

    // Saturation: 20 stall cycles on a 4-bit counter.
    for (int i = 0; i < 20; i++)
      apply(mk("sat", 0, 1,0,0,0, 0,0,0,1, 0, (i > 15) ? 15 : i));
    apply(mk("sat_hold",  0, 0,0,0,0, 1,1,0,0, 0, 15));
    apply(mk("clr_st",    0, 1,0,0,1, 0,0,0,1, 0, 15));
    apply(mk("clr_wins",  0, 0,0,0,0, 1,1,0,0, 0, 0));

    // Reset in the middle of DRAIN.
    apply(mk("pre_st",    0, 1,0,0,0, 0,0,0,1, 0, 0));
    apply(mk("md_hlt",    0, 0,1,0,0, 0,0,0,1, 0, 1));
    apply(mk("md_d1",     0, 0,0,0,0, 0,0,0,1, 0, 1));
    apply(mk("md_d2",     0, 0,0,0,0, 0,0,0,1, 0, 1));
    apply(mk("md_rst",    1, 0,0,0,0, 0,0,0,1, 0, 0));
    for (int i = 0; i < 5; i++)
      apply(mk("md_run", 0, 0,0,0,0, 1,1,0,0, 0, 0));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
